// File: rtl/sdram_frame_writer_pkg.sv
// Shared types and widths for the camera-to-SDRAM frame writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_frame_writer_pkg;

  localparam int PIX_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_BURST,
    S_NEXT
  } state_t;

endpackage

// File: rtl/i_avl_bus.sv
// Avalon-style burst bus between a write master and the SDRAM controller slave port.
// Latency: n/a (wires only).
// Backpressure: slave stalls a beat by holding request_ready low.
interface i_avl_bus;
  logic [31:0] address;
  logic [3:0]  byte_en;
  logic        write;
  logic [31:0] write_data;
  logic        begin_burst_transfer;
  logic [7:0]  burst_count;
  logic        request_ready;
  logic        read;
  logic        resp_ready;

  modport master (
    output address, byte_en, write, write_data, begin_burst_transfer,
           burst_count, read, resp_ready,
    input  request_ready
  );

  modport slave (
    input  address, byte_en, write, write_data, begin_burst_transfer,
           burst_count, read, resp_ready,
    output request_ready
  );
endinterface

// File: rtl/fifo_sync_ram.sv
// Show-ahead synchronous FIFO; the head word is always presented on rd_data.
// Latency: a word written at edge n is visible at the head by edge n+1.
// Backpressure: writes while full are ignored; the caller sees full and accounts for the drop.
module fifo_sync_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  // DEPTH is expected to be a power of two so the pointers wrap naturally.
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage array: written only when there is room.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; a simultaneous write and read leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rest || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/sdram_frame_writer.sv
// Packs RGB565 pixel pairs into 32-bit words and writes one frame as fixed-length SDRAM bursts.
// Latency: pixel pair to FIFO head 1 cycle; write asserts 1 cycle after BURST_LEN words are buffered.
// Backpressure: slave stalls via request_ready (data held); pixels have none, so a full FIFO drops words and sets overflow.
module sdram_frame_writer
  import sdram_frame_writer_pkg::*;
#(
  parameter logic [31:0] FRAME_BASE  = 32'h0000_0000,
  parameter int unsigned FRAME_WORDS = 153600,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  i_avl_bus.master         avl_m0,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow
);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int          BW          = $clog2(BURST_LEN) + 1;
  localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_LEN);
  localparam logic [31:0] LAST_WORD   = 32'(FRAME_WORDS);

  state_t            state;
  logic              phase;
  logic [PIX_W-1:0]  hi_pix;
  logic              restart_pend;
  logic [31:0]       word_cnt;
  logic [BW-1:0]     beat_cnt;
  logic [31:0]       address_q;
  logic              write_q;
  logic              bbt_q;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic [WORD_W-1:0] fifo_head;
  logic              accept;
  logic              flush;
  logic              pix_ok;
  logic              fifo_wr;

  // write is only ever high in S_BURST, so this is exactly a beat acceptance.
  assign accept = write_q && avl_m0.request_ready;

  // A start outside a burst flushes at once; a start inside a burst waits for S_NEXT.
  assign flush = (frame_start && (state != S_BURST)) ||
                 ((state == S_NEXT) && restart_pend);

  // Pixels count only inside a live frame; a start pulse and a pending restart discard them.
  assign pix_ok  = pix_valid && (state != S_IDLE) && !restart_pend && !frame_start;
  assign fifo_wr = pix_ok && phase;

  fifo_sync_ram #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rest    (rest),
    .flush   (flush),
    .wr_en   (fifo_wr),
    .wr_data ({hi_pix, pix_data}),
    .rd_en   (accept),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  assign avl_m0.address              = address_q;
  assign avl_m0.write                = write_q;
  assign avl_m0.begin_burst_transfer = bbt_q;
  assign avl_m0.write_data           = fifo_head;
  assign avl_m0.byte_en              = 4'hF;
  assign avl_m0.burst_count          = 8'(BURST_LEN - 1);
  assign avl_m0.read                 = 1'b0;
  assign avl_m0.resp_ready           = 1'b0;

  // Frame sequencer: packs pixels, tracks the frame, and drives registered burst controls.
  always_ff @(posedge clk) begin
    if (rest) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      hi_pix       <= '0;
      restart_pend <= 1'b0;
      word_cnt     <= '0;
      beat_cnt     <= '0;
      address_q    <= FRAME_BASE;
      write_q      <= 1'b0;
      bbt_q        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (pix_ok) begin
        phase <= ~phase;
        if (!phase) hi_pix <= pix_data;
      end
      if (fifo_wr && fifo_full) overflow <= 1'b1;
      if (frame_start) phase <= 1'b0;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state        <= S_FILL;
            address_q    <= FRAME_BASE;
            word_cnt     <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            restart_pend <= 1'b0;
          end
        end

        S_FILL: begin
          if (frame_start) begin
            address_q <= FRAME_BASE;
            word_cnt  <= '0;
            overflow  <= 1'b0;
          end else if (fifo_count >= CW'(BURST_LEN)) begin
            state    <= S_BURST;
            write_q  <= 1'b1;
            bbt_q    <= 1'b1;
            beat_cnt <= '0;
          end
        end

        S_BURST: begin
          // The controller cannot abort a burst, so a start is only remembered here.
          if (frame_start) restart_pend <= 1'b1;
          if (accept) begin
            word_cnt <= word_cnt + 32'd1;
            if (beat_cnt == BW'(BURST_LEN - 1)) begin
              write_q   <= 1'b0;
              bbt_q     <= 1'b0;
              address_q <= address_q + BURST_BYTES;
              state     <= S_NEXT;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        S_NEXT: begin
          // A restart wins over completion: the old frame is abandoned without frame_done.
          if (restart_pend || frame_start) begin
            address_q    <= FRAME_BASE;
            word_cnt     <= '0;
            overflow     <= 1'b0;
            restart_pend <= 1'b0;
            state        <= S_FILL;
          end else if (word_cnt == LAST_WORD) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state <= S_FILL;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_frame_writer.sv
// Randomized scoreboard bench for sdram_frame_writer with a queue-based frame model.
// Latency: n/a.
// Backpressure: request_ready driven fixed or randomly per test.
module tb_sdram_frame_writer;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          FW    = 64;
  localparam int          BL    = 16;
  localparam int          DEPTH = 32;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  logic        ready_fix = 1'b1;
  logic        ready_rnd = 1'b1;
  bit          ready_rand = 1'b0;

  i_avl_bus avl ();
  assign avl.request_ready = ready_rand ? ready_rnd : ready_fix;

  sdram_frame_writer #(
    .FRAME_BASE  (BASE),
    .FRAME_WORDS (FW),
    .BURST_LEN   (BL),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .avl_m0      (avl),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ready_rand) begin
      #1;
      ready_rnd = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          acc_total = 0;
  int          done_seen = 0;
  logic [31:0] first_word = 32'h0;

  // Reference model state: one frame is a sequence of pixel pairs laid out linearly.
  bit          mdl_in_frame = 1'b0;
  bit          mdl_phase = 1'b0;
  bit          mdl_ovf = 1'b0;
  logic [15:0] mdl_hi = 16'h0;
  int          mdl_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // New frame: words at or beyond keep_below are flushed, words below it finish their burst.
  task automatic mdl_start(input int keep_below);
    while (exp_q.size() > 0 && exp_q[$].idx >= keep_below) void'(exp_q.pop_back());
    mdl_in_frame = 1'b1;
    mdl_phase    = 1'b0;
    mdl_idx      = 0;
    mdl_ovf      = 1'b0;
  endtask

  task automatic mdl_reset();
    exp_q.delete();
    mdl_in_frame = 1'b0;
    mdl_phase    = 1'b0;
    mdl_ovf      = 1'b0;
  endtask

  // A word lands at frame position mdl_idx if the buffer has room; its burst starts at the aligned block.
  task automatic mdl_pixel(input logic [15:0] p);
    logic [31:0] w;
    if (!mdl_in_frame) return;
    if (!mdl_phase) begin
      mdl_hi    = p;
      mdl_phase = 1'b1;
    end else begin
      mdl_phase = 1'b0;
      w = {mdl_hi, p};
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back('{w, BASE + 32'(4 * BL * (mdl_idx / BL)), mdl_idx});
        mdl_idx++;
      end else begin
        mdl_ovf = 1'b1;
      end
    end
  endtask

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_wd = 32'h0;
  logic [31:0] prev_addr = 32'h0;
  exp_t        e;
  always @(negedge clk) begin
    if (rest) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_write_held", 32'(avl.write), 32'd1);
        chk("stall_data_stable", avl.write_data, prev_wd);
        chk("stall_addr_stable", avl.address, prev_addr);
      end
      if (avl.write && avl.request_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h at %h, expected no beat", avl.write_data, avl.address);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", avl.write_data, e.data);
          chk("beat_addr", avl.address, e.addr);
          chk("beat_ctrl", {avl.begin_burst_transfer, avl.byte_en, avl.burst_count},
              {1'b1, 4'hF, 8'(BL - 1)});
          if (e.idx == 0) first_word = avl.write_data;
        end
        acc_total++;
      end
      prev_stall = avl.write && !avl.request_ready;
      prev_wd    = avl.write_data;
      prev_addr  = avl.address;
    end
    if (frame_done) done_seen++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit v, input logic [15:0] p);
    pix_valid = v;
    pix_data  = p;
    if (v) mdl_pixel(p);
    tick(1);
    pix_valid = 1'b0;
  endtask

  task automatic pulse_start(input int keep_below);
    frame_start = 1'b1;
    mdl_start(keep_below);
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_acc(input string name, input int target);
    int n = 0;
    while (acc_total < target && n < 3000) begin
      tick(1);
      n++;
    end
    chk(name, 32'(acc_total), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int acc1;
    int d0;
    int n;
    int sent;

    // Reset state
    tick(3);
    chk("rst_write", 32'(avl.write), 32'd0);
    chk("rst_bbt", 32'(avl.begin_burst_transfer), 32'd0);
    chk("rst_address", avl.address, BASE);
    chk("rst_burst_count", 32'(avl.burst_count), 32'(BL - 1));
    chk("rst_byte_en", 32'(avl.byte_en), 32'hF);
    chk("rst_read_resp", {30'd0, avl.read, avl.resp_ready}, 32'd0);
    chk("rst_flags", {29'd0, busy, frame_done, overflow}, 32'd0);
    rest = 1'b0;
    tick(2);

    // Single frame, slave always ready
    d0 = done_seen;
    acc0 = acc_total;
    pulse_start(0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 2 * FW; i++) send(1'b1, 16'(i));
    wait_acc("t1_accepts", acc0 + FW);
    tick(5);
    chk("t1_first_word", first_word, 32'h0000_0001);
    chk("t1_done_pulses", 32'(done_seen - d0), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'(mdl_ovf));

    // Stalled slave with random pixel gaps
    d0 = done_seen;
    acc0 = acc_total;
    pulse_start(0);
    ready_rand = 1'b1;
    sent = 0;
    n = 0;
    while (sent < 2 * FW && n < 4000) begin
      if ($urandom_range(0, 1) == 1) begin
        send(1'b1, 16'(sent));
        sent++;
      end else begin
        send(1'b0, 16'h0);
      end
      n++;
    end
    wait_acc("t2_accepts", acc0 + FW);
    ready_rand = 1'b0;
    tick(5);
    chk("t2_done_pulses", 32'(done_seen - d0), 32'd1);
    chk("t2_overflow", 32'(overflow), 32'(mdl_ovf));

    // Overflow: slave blocked while 80 pixels arrive
    acc0 = acc_total;
    d0 = done_seen;
    ready_fix = 1'b0;
    pulse_start(0);
    for (int i = 0; i < 80; i++) send(1'b1, 16'($urandom));
    tick(3);
    chk("t3_overflow_set", 32'(overflow), 32'(mdl_ovf));
    chk("t3_write_waiting", 32'(avl.write), 32'd1);
    ready_fix = 1'b1;
    wait_acc("t3_drain", acc0 + DEPTH);
    tick(20);
    chk("t3_fifo_held_depth", 32'(acc_total - acc0), 32'(DEPTH));
    pulse_start(0);
    chk("t3_overflow_cleared", 32'(overflow), 32'd0);
    chk("t3_busy_restart", 32'(busy), 32'd1);
    chk("t3_no_done", 32'(done_seen - d0), 32'd0);

    // Restart during the 5th beat of burst 2
    acc0 = acc_total;
    d0 = done_seen;
    n = 0;
    while (acc_total - acc0 < BL + 4 && n < 1000) begin
      send(1'b1, 16'($urandom));
      n++;
    end
    chk("t4_reach_beat5", 32'(acc_total - acc0), 32'(BL + 4));
    pulse_start(((acc_total - acc0) / BL + 1) * BL);
    wait_acc("t4_burst_completes", acc0 + 2 * BL);
    tick(10);
    chk("t4_flushed", 32'(acc_total - acc0), 32'(2 * BL));
    chk("t4_overflow", 32'(overflow), 32'd0);
    chk("t4_no_done", 32'(done_seen - d0), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    acc1 = acc_total;
    for (int i = 0; i < 2 * FW; i++) send(1'b1, 16'($urandom));
    wait_acc("t4_new_frame", acc1 + FW);
    tick(5);
    chk("t4_done_once", 32'(done_seen - d0), 32'd1);

    // Reset during beat 8 of the first burst
    acc0 = acc_total;
    d0 = done_seen;
    pulse_start(0);
    n = 0;
    while (acc_total - acc0 < 7 && n < 1000) begin
      send(1'b1, 16'($urandom));
      n++;
    end
    rest = 1'b1;
    mdl_reset();
    tick(1);
    rest = 1'b0;
    chk("t5_write_after_rst", 32'(avl.write), 32'd0);
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    chk("t5_addr_after_rst", avl.address, BASE);
    tick(10);
    chk("t5_idle_no_beats", 32'(acc_total - acc0), 32'd7);
    acc1 = acc_total;
    pulse_start(0);
    for (int i = 0; i < 2 * FW; i++) send(1'b1, 16'($urandom));
    wait_acc("t5_new_frame", acc1 + FW);
    tick(5);
    chk("t5_done_once", 32'(done_seen - d0), 32'd1);
    chk("t5_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_frame_writer.md
# sdram_frame_writer

Camera-side write master that sits directly upstream of the SDRAM controller. It packs the 16-bit RGB565 pixel stream into 32-bit words and buffers them in a sync FIFO. It then issues fixed-length Avalon-style burst writes into a linear frame buffer through the controller's `avl_s0` slave port. One frame is written per `frame_start`.

## Interface
- `FRAME_BASE`, 32'h0000_0000: byte address of the frame buffer. Must be aligned to 4*`BURST_LEN`.
- `FRAME_WORDS`, 153600: 32-bit words per frame (640x480/2). Must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 16: words per burst. Must be a power of two, ≤256 and a divisor of 256, so no burst crosses a 1 KB SDRAM row.
- `FIFO_DEPTH`, 64: words of buffering. Must be ≥2*`BURST_LEN`.

Ports:
- `clk`, in, 1: system clock, same domain as the SDRAM controller.
- `rest`, in, 1: synchronous, active-high reset.
- `frame_start`, in, 1: one-cycle pulse; the next pixel belongs to a new frame.
- `pix_valid`, in, 1: `pix_data` is valid this cycle.
- `pix_data`, in, 16: RGB565 pixel.
- `avl_m0`, i_avl_bus.master, n/a: bus to `sdram_controller.avl_s0`. Signals used: `address`, `byte_en`, `write`, `write_data`, `begin_burst_transfer`, `burst_count`, `request_ready`. `read` and `resp_ready` are tied 0.
- `busy`, out, 1: a frame is in progress.
- `frame_done`, out, 1: one-cycle pulse after the last word of a frame is accepted.
- `overflow`, out, 1: sticky flag; a word was dropped in the current frame.

## Operation
- Pixel packer:
  - The first pixel of a pair goes to bits [31:16], the second to [15:0].
  - The FIFO write happens on the second pixel.
  - `frame_start` clears the pair phase.
- FIFO writes when full: the word is dropped, `overflow` is set, and the occupancy counter is unchanged.
- Pixels outside a frame (state `S_IDLE`) are ignored.
- Occupancy counter:
  - Width is clog2(`FIFO_DEPTH`)+1.
  - +1 on a FIFO write, -1 on a word acceptance, unchanged when both happen in the same cycle.
- FSM states:
  - `S_IDLE`: `frame_start` → `S_FILL`. Loads `address`=`FRAME_BASE`, clears the word count and `overflow`, sets `busy`.
  - `S_FILL`: occupancy ≥`BURST_LEN` → `S_BURST`.
  - `S_BURST`:
    - Outputs held: `write`=1, `begin_burst_transfer`=1, `burst_count`=`BURST_LEN`-1, `byte_en`=4'hF, `write_data`=FIFO head.
    - A word is accepted on every edge where `write`&&`request_ready`. Each acceptance pops the FIFO and increments the beat counter.
    - After the `BURST_LEN`th acceptance: `write` and `begin_burst_transfer` drop, `address`+=4*`BURST_LEN`, and the FSM moves to `S_NEXT`.
  - `S_NEXT`:
    - Word count reaches `FRAME_WORDS` → `S_IDLE`; pulse `frame_done`, clear `busy`.
    - A restart is pending → `S_FILL`, restart taken.
    - Otherwise → `S_FILL`.
- `frame_start` while `busy`:
  - The burst in flight completes (the controller cannot abort a burst) and a restart is latched.
  - In `S_NEXT`, the restart flushes the FIFO and pair phase, reloads `FRAME_BASE`, clears the word count and `overflow`, and skips `frame_done`.
  - Pixels arriving while the restart is pending are discarded.
  - `frame_start` in `S_FILL` restarts immediately, with the same flush.
- Arithmetic:
  - Addresses are byte addresses and wrap modulo 2^32.
  - Word count is 32 bits and compares equal to `FRAME_WORDS`.

## Timing
- Reset values: `write`=0, `begin_burst_transfer`=0, `address`=`FRAME_BASE`, `burst_count`=`BURST_LEN`-1, `byte_en`=4'hF, `read`=0, `resp_ready`=0, `busy`=0, `frame_done`=0, `overflow`=0. State `S_IDLE`, FIFO flushed, pair phase 0.
- Reset mid-burst: outputs return to these values on the next edge. The controller's state is not the block's concern.
- Pixel-to-FIFO latency: the second pixel sampled at edge n is visible at the FIFO head by edge n+1.
- `S_FILL`→`S_BURST`: `write` asserts on the edge after occupancy reaches `BURST_LEN`.
- `write_data` changes only on the edge after an acceptance.
- `frame_done` is asserted the cycle after the `S_NEXT` decision.
- Simultaneous FIFO write and pop in the same cycle are both honoured.

## Structure
- Package `sdram_frame_writer_pkg`: the FSM state enum (`S_IDLE`, `S_FILL`, `S_BURST`, `S_NEXT`) and `PIX_W`=16, `WORD_W`=32.
- Sub-module: the existing `fifo_sync_ram` (show-ahead, WIDTH=32, DEPTH=`FIFO_DEPTH`). Its `rest` input is driven by `rest`, and its `flush` is driven by the restart/`frame_start` flush.

## Test plan
Bench parameters: `FRAME_WORDS`=64, `BURST_LEN`=16, `FIFO_DEPTH`=32, `FRAME_BASE`=32'h0000_1000.
- Single frame: `frame_start`, then 128 pixels 0..127 with `request_ready` always 1 → 4 bursts at 0x1000, 0x1040, 0x1080, 0x10C0. The first word is 32'h0000_0001. `frame_done` pulses once, `overflow`=0.
- Stalled slave: `request_ready` toggling 0/1 → the same 64 words in order, and `write_data` stable across every stall cycle.
- Overflow: `request_ready`=0 while 80 pixels arrive → FIFO holds 32 words and `overflow`=1. Releasing `request_ready` drains the first 32 words unchanged.
- Mid-burst `frame_start` during the 5th beat of burst 2 → burst 2 completes with 16 acceptances, the next burst goes to 0x1000, no `frame_done` pulse, and `overflow` is cleared.
- Reset mid-burst: assert `rest` for one cycle during beat 8 → the next cycle shows `write`=0, `busy`=0, and the FIFO is empty. A new frame then writes from 0x1000 correctly.
